// File: rtl/output_requant_fifo_pkg.sv
// ============================================================================
// Package : out_pkg
// Shared types, coordinate widths and the requantization reference function.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package out_pkg;

    localparam int ACC_W = 32;
    localparam int IO_W  = 16;
    localparam int X_W   = $clog2(1024);
    localparam int Y_W   = $clog2(1024);
    localparam int CH_W  = $clog2(64);

    typedef struct packed {
        logic signed [IO_W-1:0] data;
        logic [X_W-1:0]         x;
        logic [Y_W-1:0]         y;
        logic [CH_W-1:0]        ch;
    } out_beat_t;

    // Round-half-up arithmetic shift, optional ReLU, saturate to IO_W.
    function automatic logic signed [IO_W-1:0] sat_round(
        input logic signed [ACC_W-1:0] acc,
        input logic [4:0]              shift,
        input logic                    relu
    );
        logic signed [63:0] v;
        logic signed [63:0] sat_max;
        logic signed [63:0] sat_min;
        sat_max = (64'sd1 <<< (IO_W - 1)) - 64'sd1;
        sat_min = -(64'sd1 <<< (IO_W - 1));
        v = {{(64-ACC_W){acc[ACC_W-1]}}, acc};
        if (shift != 5'd0) begin
            v = (v + (64'sd1 <<< (shift - 5'd1))) >>> shift;
        end
        if (relu && (v < 64'sd0)) begin
            v = 64'sd0;
        end else if (v > sat_max) begin
            v = sat_max;
        end else if (v < sat_min) begin
            v = sat_min;
        end
        return v[IO_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/output_requant_fifo_sync_fifo.sv
// ============================================================================
// Module  : sync_fifo
// Single-clock FIFO, registered memory, first-word fall-through read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra MSB on the pointers separates full from empty.
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign count     = r_wr_ptr - r_rd_ptr;
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/output_requant_fifo.sv
// ============================================================================
// Module  : output_requant_fifo
// Requantizes accumulator beats (round/shift/ReLU/saturate) and buffers them.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module output_requant_fifo
    import out_pkg::*;
#(
    parameter int ACCUMULATION_WIDTH = 32,
    parameter int IO_DATA_WIDTH      = 16,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int FIFO_DEPTH         = 16,
    parameter int AF_MARGIN          = 3
) (
    input  logic                                    clk,
    input  logic                                    arst_in,
    input  logic                                    clear,
    input  logic [4:0]                              shift_amt,
    input  logic                                    relu_en,
    input  logic signed [ACCUMULATION_WIDTH-1:0]    acc_in,
    input  logic                                    acc_valid,
    input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]    acc_x,
    input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]   acc_y,
    input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   acc_ch,
    output logic                                    almost_full,
    output logic signed [IO_DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]    out_x,
    output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]   out_y,
    output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   out_ch,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic                                    overflow,
    output logic [15:0]                             drop_count
);

    localparam int AW       = ACCUMULATION_WIDTH;
    localparam int OW       = IO_DATA_WIDTH;
    localparam int XW       = $clog2(FEATURE_MAP_WIDTH);
    localparam int YW       = $clog2(FEATURE_MAP_HEIGHT);
    localparam int CW       = $clog2(OUTPUT_NB_CHANNELS);
    localparam int FW       = OW + XW + YW + CW;
    localparam int PW       = $clog2(FIFO_DEPTH);
    localparam int AF_LEVEL_I = FIFO_DEPTH - AF_MARGIN;
    localparam logic [PW:0] AF_LEVEL = AF_LEVEL_I[PW:0];

    // S1: round and shift in AW+1 bits so the bias add cannot wrap.
    logic signed [AW:0] w_ext;
    logic signed [AW:0] w_bias;
    logic signed [AW:0] w_rnd;

    always_comb begin
        w_ext  = {acc_in[AW-1], acc_in};
        w_bias = '0;
        if (shift_amt != 5'd0) begin
            w_bias = {{AW{1'b0}}, 1'b1} << (shift_amt - 5'd1);
        end
        w_rnd = (w_ext + w_bias) >>> shift_amt;
    end

    logic               r_s1_valid;
    logic signed [AW:0] r_s1_val;
    logic               r_s1_relu;
    logic [XW-1:0]      r_s1_x;
    logic [YW-1:0]      r_s1_y;
    logic [CW-1:0]      r_s1_ch;

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            r_s1_valid <= 1'b0;
            r_s1_val   <= '0;
            r_s1_relu  <= 1'b0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_ch    <= '0;
        end else begin
            r_s1_valid <= acc_valid && !clear;
            r_s1_val   <= w_rnd;
            r_s1_relu  <= relu_en;
            r_s1_x     <= acc_x;
            r_s1_y     <= acc_y;
            r_s1_ch    <= acc_ch;
        end
    end

    // S2: value fits when all bits above the output sign bit match it.
    logic signed [OW-1:0] w_sat;

    always_comb begin
        w_sat = r_s1_val[OW-1:0];
        if (r_s1_relu && r_s1_val[AW]) begin
            w_sat = '0;
        end else if (!r_s1_val[AW] && (|r_s1_val[AW-1:OW-1])) begin
            w_sat = {1'b0, {(OW-1){1'b1}}};
        end else if (r_s1_val[AW] && !(&r_s1_val[AW-1:OW-1])) begin
            w_sat = {1'b1, {(OW-1){1'b0}}};
        end
    end

    logic                 r_s2_valid;
    logic signed [OW-1:0] r_s2_data;
    logic [XW-1:0]        r_s2_x;
    logic [YW-1:0]        r_s2_y;
    logic [CW-1:0]        r_s2_ch;

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_x     <= '0;
            r_s2_y     <= '0;
            r_s2_ch    <= '0;
        end else begin
            r_s2_valid <= r_s1_valid && !clear;
            r_s2_data  <= w_sat;
            r_s2_x     <= r_s1_x;
            r_s2_y     <= r_s1_y;
            r_s2_ch    <= r_s1_ch;
        end
    end

    logic          w_full;
    logic          w_empty;
    logic [PW:0]   w_count;
    logic [PW:0]   w_count_next;
    logic [FW-1:0] w_dout;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    assign w_pop  = !w_empty && out_ready;
    assign w_push = r_s2_valid && (!w_full || w_pop);
    assign w_drop = r_s2_valid && w_full && !w_pop;
    assign w_count_next = w_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (arst_in),
        .clear (clear),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({r_s2_data, r_s2_x, r_s2_y, r_s2_ch}),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Memory is not reset, so the head is masked while the FIFO is empty.
    assign out_valid = !w_empty;
    assign {out_data, out_x, out_y, out_ch} = w_empty ? '0 : w_dout;

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            drop_count  <= '0;
        end else if (clear) begin
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            drop_count  <= '0;
        end else begin
            almost_full <= (w_count_next >= AF_LEVEL);
            if (w_drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_output_requant_fifo.sv
// ============================================================================
// Module  : tb_output_requant_fifo
// Scoreboard bench for output_requant_fifo: directed vectors plus a random run.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_output_requant_fifo;
    import out_pkg::*;

    logic               clk = 1'b0;
    logic               arst_in = 1'b1;
    logic               clear = 1'b0;
    logic [4:0]         shift_amt = '0;
    logic               relu_en = 1'b0;
    logic signed [31:0] acc_in = '0;
    logic               acc_valid = 1'b0;
    logic [9:0]         acc_x = '0;
    logic [9:0]         acc_y = '0;
    logic [5:0]         acc_ch = '0;
    logic               almost_full;
    logic signed [15:0] out_data;
    logic [9:0]         out_x;
    logic [9:0]         out_y;
    logic [5:0]         out_ch;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               overflow;
    logic [15:0]        drop_count;

    int tests = 0;
    int fails = 0;
    int bid   = 0;
    out_beat_t exp_q[$];

    output_requant_fifo dut (
        .clk         (clk),
        .arst_in     (arst_in),
        .clear       (clear),
        .shift_amt   (shift_amt),
        .relu_en     (relu_en),
        .acc_in      (acc_in),
        .acc_valid   (acc_valid),
        .acc_x       (acc_x),
        .acc_y       (acc_y),
        .acc_ch      (acc_ch),
        .almost_full (almost_full),
        .out_data    (out_data),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_ch      (out_ch),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every accepted head is compared against the oldest expected beat.
    always @(negedge clk) begin
        if (!arst_in && !clear && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 1, 0);
            end else begin
                out_beat_t e;
                e = exp_q.pop_front();
                check("out_data", longint'(out_data), longint'(e.data));
                check("out_x", longint'(out_x), longint'(e.x));
                check("out_y", longint'(out_y), longint'(e.y));
                check("out_ch", longint'(out_ch), longint'(e.ch));
            end
        end
    end

    task automatic beat(input logic signed [31:0] a, input logic [4:0] s, input logic r,
                        input logic signed [15:0] ev, input bit expect_push);
        out_beat_t e;
        acc_in    = a;
        shift_amt = s;
        relu_en   = r;
        acc_x     = 10'(bid);
        acc_y     = 10'(bid * 7 + 3);
        acc_ch    = 6'(bid * 5);
        acc_valid = 1'b1;
        e.data = ev;
        e.x    = acc_x;
        e.y    = acc_y;
        e.ch   = acc_ch;
        if (expect_push) exp_q.push_back(e);
        bid++;
        @(posedge clk); #1;
        acc_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic latency_check(input string name);
        // called right after the beat's sampling edge
        @(negedge clk); check({name, "_c1"}, out_valid, 0);
        @(negedge clk); check({name, "_c2"}, out_valid, 0);
        @(negedge clk); check({name, "_c3"}, out_valid, 1);
    endtask

    task automatic load_5_plus_2();
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) beat(32'(i), 5'd0, 1'b0, 16'(i), 1'b1);
    endtask

    initial begin
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_almost_full", almost_full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_out_coord", {out_x, out_y, out_ch}, 0);
        @(negedge clk); arst_in = 1'b0;
        @(posedge clk); #1;

        // Directed requantization vectors with latency check on the first.
        out_ready = 1'b1;
        beat(32'sd1000, 5'd4, 1'b0, 16'sd63, 1'b1);
        latency_check("lat");
        beat(32'sh7FFF_FFFF, 5'd0, 1'b0, 16'sd32767, 1'b1);
        beat(32'sh8000_0000, 5'd0, 1'b0, -16'sd32768, 1'b1);
        beat(-32'sd5, 5'd0, 1'b1, 16'sd0, 1'b1);
        beat(-32'sd5, 5'd1, 1'b0, -16'sd2, 1'b1);
        beat(32'sd7, 5'd1, 1'b0, 16'sd4, 1'b1);
        beat(-32'sd7, 5'd2, 1'b0, -16'sd2, 1'b1);
        beat(32'sh7FFF_FFFF, 5'd31, 1'b0, 16'sd1, 1'b1);
        beat(32'sh8000_0000, 5'd31, 1'b0, -16'sd1, 1'b1);
        beat(32'sd100000, 5'd0, 1'b1, 16'sd32767, 1'b1);
        beat(-32'sd100000, 5'd2, 1'b0, -16'sd25000, 1'b1);
        drain("directed_drain");

        // 20 beats into a stalled FIFO: almost_full at 13, last four dropped.
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            beat(32'(i * 16), 5'd4, 1'b0, 16'(i), i < 16);
            if (i == 13) check("af_at_count12", almost_full, 0);
            if (i == 14) check("af_at_count13", almost_full, 1);
        end
        idle(3);
        check("fill_overflow", overflow, 1);
        check("fill_drop_count", drop_count, 4);
        check("fill_almost_full", almost_full, 1);
        drain("fill_drain");

        // Full FIFO with simultaneous push and pop never drops.
        do_clear();
        check("clr_overflow", overflow, 0);
        check("clr_drop_count", drop_count, 0);
        out_ready = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i == 18) out_ready = 1'b1;
            beat(32'(-i), 5'd0, 1'b0, 16'(-i), 1'b1);
            if (i >= 18) check("full_pp_af", almost_full, 1);
        end
        idle(2);
        check("full_pp_overflow", overflow, 0);
        check("full_pp_drop_count", drop_count, 0);
        drain("full_pp_drain");

        // Clear with 5 queued and 2 in flight.
        load_5_plus_2();
        do_clear();
        @(negedge clk);
        check("clr_flush_valid", out_valid, 0);
        check("clr_flush_overflow", overflow, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        beat(32'sd4660, 5'd0, 1'b0, 16'sd4660, 1'b1);
        latency_check("clr_lat");
        drain("clr_drain");

        // Asynchronous reset with 5 queued and 2 in flight.
        load_5_plus_2();
        #1 arst_in = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_overflow", overflow, 0);
        exp_q.delete();
        @(negedge clk); arst_in = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        beat(-32'sd77, 5'd0, 1'b0, -16'sd77, 1'b1);
        latency_check("arst_lat");
        drain("arst_drain");

        // Random run against the reference function, stalling on almost_full.
        begin
            int sent;
            int cyc;
            sent = 0;
            cyc  = 0;
            while (sent < 10000 && cyc < 40000) begin
                out_ready = ($urandom_range(0, 3) != 0);
                if (almost_full) begin
                    idle(1);
                end else begin
                    logic signed [31:0] a;
                    logic [4:0] s;
                    logic r;
                    a = $urandom;
                    if ($urandom_range(0, 1) == 1) a = a >>> $urandom_range(8, 24);
                    s = 5'($urandom_range(0, 31));
                    r = 1'($urandom_range(0, 1));
                    beat(a, s, r, sat_round(a, s, r), 1'b1);
                    sent++;
                end
                cyc++;
            end
            check("rand_sent", sent, 10000);
            drain("rand_drain");
            check("rand_drop_count", drop_count, 0);
            check("rand_overflow", overflow, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
